// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   uart_state_t              - character FSM states (IDLE, START, DATA, STOP)
//   UART_DEFAULT_CLKS_PER_BIT - 115200 baud from a 100 MHz clock
//   UART_LINE_IDLE            - level of the line between characters
//   UART_START_LEVEL          - level of the start bit
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam logic UART_LINE_IDLE            = 1'b1;
  localparam logic UART_START_LEVEL          = 1'b0;

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one 8N1 character.
//   clock, reset : system clock, synchronous active-high reset
//   i_start      : load i_byte; honoured when idle or in the last stop-bit cycle
//   i_byte       : character to send
//   o_serial     : registered line output, idle high
//   o_done       : high during the last cycle of the stop bit (combinational)
// Because o_done is asserted in the final stop-bit cycle, a caller that
// answers it with i_start gets the next start bit with no idle gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_serial,
  output logic       o_done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;
  logic          load;

  assign bit_end = (clk_cnt == LAST_CLK);
  assign o_done  = (state == ST_STOP) && bit_end;
  assign load    = i_start && ((state == ST_IDLE) || o_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      o_serial <= UART_LINE_IDLE;
    end else if (load) begin
      state    <= ST_START;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= i_byte;
      o_serial <= UART_START_LEVEL;
    end else begin
      case (state)
        ST_IDLE: begin
          o_serial <= UART_LINE_IDLE;
        end
        ST_START: begin
          if (bit_end) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            o_serial <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state    <= ST_STOP;
              o_serial <= UART_LINE_IDLE;
            end else begin
              // shift[1] becomes the next bit once the register shifts right
              bit_idx  <= bit_idx + 1'b1;
              shift    <= {1'b0, shift[7:1]};
              o_serial <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends a 1..MAX_BYTES-byte word as back-to-back 8N1
// characters, with selectable byte order and an optional checksum character.
//   clock, reset : system clock, synchronous active-high reset
//   i_valid      : frame request
//   o_ready      : block can accept a frame
//   i_data       : payload, byte k = i_data[8k+7:8k]
//   i_num_bytes  : payload length N (legal 1..MAX_BYTES)
//   o_serial     : UART line, idle high
//   o_busy       : frame in progress
//   o_done       : one-cycle pulse when the last stop bit has ended
//   o_error      : one-cycle pulse when a request with illegal N was accepted
//
// Handshake: a request transfers on every rising edge where i_valid and
// o_ready are both high; i_data/i_num_bytes are captured on that edge and
// ignored afterwards. o_ready never depends on i_valid. A request with an
// illegal length is consumed (o_error) without leaving the ready state.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int MAX_BYTES    = 4,
  parameter int MSB_FIRST    = 1,
  parameter int CHECKSUM_EN  = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [8*MAX_BYTES-1:0]         i_data,
  input  logic [$clog2(MAX_BYTES+1)-1:0] i_num_bytes,
  output logic                           o_serial,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_error
);

  localparam int            NW    = $clog2(MAX_BYTES + 1);
  localparam logic [NW-1:0] MAX_N = NW'(MAX_BYTES);

  logic [8*MAX_BYTES-1:0] frame_data;
  logic [NW-1:0]          frame_n;
  logic [NW-1:0]          sent_cnt;
  logic [7:0]             chk_sum;
  logic                   chk_sent;
  logic                   busy_q;
  logic                   ready_q;
  logic                   done_q;
  logic                   error_q;

  logic                   accept;
  logic                   len_bad;
  logic [NW-1:0]          first_idx;
  logic [NW-1:0]          next_idx;
  logic [7:0]             first_byte;
  logic [7:0]             next_byte;
  logic                   more_payload;
  logic                   chk_pending;
  logic                   tx_start;
  logic [7:0]             tx_byte;
  logic                   byte_done;

  function automatic logic [7:0] byte_at(input logic [8*MAX_BYTES-1:0] d,
                                         input logic [NW-1:0]          idx);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx == NW'(k)) b = d[8*k +: 8];
    end
    return b;
  endfunction

  // Ready is held low through reset and rises on the first edge after it.
  assign o_ready = ready_q & ~reset;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_error = error_q;

  assign accept  = i_valid && o_ready;
  assign len_bad = (i_num_bytes == '0) || (i_num_bytes > MAX_N);

  // The first character leaves straight from the request inputs so its start
  // bit is on the line in the cycle after acceptance.
  assign first_idx  = (MSB_FIRST != 0) ? (i_num_bytes - 1'b1) : '0;
  assign first_byte = byte_at(i_data, first_idx);

  // sent_cnt counts payload characters already handed to the serialiser.
  assign next_idx     = (MSB_FIRST != 0) ? (frame_n - 1'b1 - sent_cnt) : sent_cnt;
  assign next_byte    = byte_at(frame_data, next_idx);
  assign more_payload = (sent_cnt != frame_n);
  assign chk_pending  = (CHECKSUM_EN != 0) && !chk_sent;

  always_comb begin
    tx_start = 1'b0;
    tx_byte  = first_byte;
    if (!busy_q) begin
      if (accept && !len_bad) tx_start = 1'b1;
    end else if (byte_done) begin
      if (more_payload) begin
        tx_start = 1'b1;
        tx_byte  = next_byte;
      end else if (chk_pending) begin
        tx_start = 1'b1;
        tx_byte  = chk_sum;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_data <= '0;
      frame_n    <= '0;
      sent_cnt   <= '0;
      chk_sum    <= '0;
      chk_sent   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (!busy_q) begin
        ready_q <= 1'b1;
        if (accept) begin
          if (len_bad) begin
            error_q <= 1'b1;
          end else begin
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            frame_data <= i_data;
            frame_n    <= i_num_bytes;
            sent_cnt   <= NW'(1);
            chk_sum    <= first_byte;
            chk_sent   <= 1'b0;
          end
        end
      end else if (byte_done) begin
        // Zero-time NEXT decision at the end of each stop bit.
        if (more_payload) begin
          sent_cnt <= sent_cnt + 1'b1;
          chk_sum  <= chk_sum + next_byte;
        end else if (chk_pending) begin
          chk_sent <= 1'b1;
        end else begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clock   (clock),
    .reset   (reset),
    .i_start (tx_start),
    .i_byte  (tx_byte),
    .o_serial(o_serial),
    .o_done  (byte_done)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
`timescale 1ns/1ps
// Bench for uart_frame_tx. Three instances share the request bus:
//   0: CLKS_PER_BIT=4,   MSB first, no checksum
//   1: CLKS_PER_BIT=4,   LSB first, checksum
//   2: CLKS_PER_BIT=868, MSB first, no checksum
// Only one instance is active at a time, so a single expected queue serves all.
module tb_uart_frame_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  valid = '0;
  logic [31:0] data  = '0;
  logic [2:0]  num   = '0;
  logic [2:0]  rdy, ser, busy, done, err;

  logic [7:0]  exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int CPB  = (g == 2) ? 868 : 4;
    localparam int MSBF = (g == 1) ? 0 : 1;
    localparam int CHK  = (g == 1) ? 1 : 0;

    uart_frame_tx #(
      .CLKS_PER_BIT(CPB),
      .MAX_BYTES   (4),
      .MSB_FIRST   (MSBF),
      .CHECKSUM_EN (CHK)
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .i_valid    (valid[g]),
      .o_ready    (rdy[g]),
      .i_data     (data),
      .i_num_bytes(num),
      .o_serial   (ser[g]),
      .o_busy     (busy[g]),
      .o_done     (done[g]),
      .o_error    (err[g])
    );

    // Line decoder: samples each bit at its centre, pops and compares.
    initial begin : mon
      logic       prev;
      logic       ok;
      logic [9:0] bits;
      logic [7:0] e;
      prev = 1'b1;
      forever begin
        @(negedge clock);
        if (!reset && prev === 1'b1 && ser[g] === 1'b0) begin
          ok   = 1'b1;
          bits = '0;
          for (int j = 0; j < 10; j++) begin
            repeat ((j == 0) ? CPB / 2 : CPB) begin
              @(negedge clock);
              if (reset) ok = 1'b0;
            end
            bits[j] = ser[g];
          end
          if (ok) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL char_unexpected inst=%0d actual=%0h expected=none", g, bits[8:1]);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("char_inst%0d", g), 32'(bits), 32'({1'b1, e, 1'b0}));
            end
          end
        end
        prev = ser[g];
      end
    end
  end

  always @(negedge clock) begin
    if ((done | err) != 3'b000) chk("done_error_exclusive", 32'(done & err), 32'd0);
  end

  // driver tasks: called at a negedge, return at the negedge of cycle t+1
  task automatic issue(input int g, input logic [31:0] d, input logic [2:0] n, output int waited);
    data     = d;
    num      = n;
    valid[g] = 1'b1;
    waited   = 0;
    while (!rdy[g]) begin
      @(negedge clock);
      waited++;
      if (waited > 200) break;
    end
    chk("accept_timeout", 32'(waited > 200), 32'd0);
    @(posedge clock);
    @(negedge clock);
    valid[g] = 1'b0;
  endtask

  task automatic send(input int g, input logic [31:0] d, input logic [2:0] n, output int waited);
    issue(g, d, n, waited);
    chk("t1_busy",   32'(busy[g]), 32'd1);
    chk("t1_ready",  32'(rdy[g]),  32'd0);
    chk("t1_serial", 32'(ser[g]),  32'd0);
  endtask

  task automatic wait_done(input int g, input int f);
    int k;
    k = 0;
    forever begin
      @(negedge clock);
      k++;
      if (done[g]) break;
      if (k > f + 20) break;
    end
    chk($sformatf("done_latency_inst%0d", g), 32'(k), 32'(f));
    chk("done_busy",   32'(busy[g]), 32'd0);
    chk("done_ready",  32'(rdy[g]),  32'd1);
    chk("done_serial", 32'(ser[g]),  32'd1);
  endtask

  task automatic send_bad(input logic [2:0] n);
    int w;
    issue(0, 32'hdeadbeef, n, w);
    chk("bad_error",  32'(err),  32'b001);
    chk("bad_ready",  32'(rdy),  32'b111);
    chk("bad_busy",   32'(busy), 32'd0);
    chk("bad_serial", 32'(ser),  32'b111);
    @(negedge clock);
    chk("bad_error_gone", 32'(err), 32'd0);
    chk("bad_ready_t2",   32'(rdy), 32'b111);
    chk("bad_serial_t2",  32'(ser), 32'b111);
  endtask

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int w;
    repeat (3) @(negedge clock);
    chk("reset_ready",  32'(rdy),  32'd0);
    chk("reset_serial", 32'(ser),  32'b111);
    chk("reset_busy",   32'(busy), 32'd0);
    chk("reset_done",   32'(done), 32'd0);
    chk("reset_error",  32'(err),  32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", 32'(rdy), 32'b111);

    // MSB-first, N=4
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hff);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hcd);
    send(0, 32'h00ff12cd, 3'd4, w);
    wait_done(0, 160);

    // LSB-first with checksum: ab+cd+25 = 19d -> 9d
    exp_q.push_back(8'hab);
    exp_q.push_back(8'hcd);
    exp_q.push_back(8'h25);
    exp_q.push_back(8'h9d);
    send(1, 32'h0025cdab, 3'd3, w);
    wait_done(1, 160);

    // single byte, then a request presented in the done cycle
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hab);
    send(0, 32'h00000002, 3'd1, w);
    wait_done(0, 40);
    send(0, 32'h000000ab, 3'd1, w);
    chk("b2b_wait_cycles", 32'(w), 32'd0);
    wait_done(0, 40);

    // illegal lengths
    send_bad(3'd0);
    send_bad(3'd5);

    // reset in the DATA bits of character 2; only character 1 completes
    exp_q.push_back(8'h11);
    send(0, 32'h11223344, 3'd4, w);
    repeat (50) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_serial", 32'(ser),  32'b111);
    chk("midreset_ready",  32'(rdy),  32'd0);
    chk("midreset_busy",   32'(busy), 32'd0);
    repeat (2) begin
      @(negedge clock);
      chk("midreset_no_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_ready_back", 32'(rdy), 32'b111);
    repeat (60) begin
      @(negedge clock);
      if (done != 3'b000) chk("abandoned_no_done", 32'(done), 32'd0);
    end
    chk("abandoned_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h10);
    send(0, 32'h00000010, 3'd1, w);
    wait_done(0, 40);

    // default bit rate, N=3: 3*10*868 = 26040
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    send(2, 32'h00414243, 3'd3, w);
    wait_done(2, 26040);

    repeat (10) @(negedge clock);
    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
